// File: rtl/ltc2600_update_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ltc2600_pkg                                                          |
// | LTC2600 command encodings and sequencer state type.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ltc2600_pkg;

  typedef enum logic [3:0] {
    CMD_WRITE_N            = 4'b0000,
    CMD_POWER_UP_N         = 4'b0001,
    CMD_WRITE_N_UPDATE_ALL = 4'b0010,
    CMD_WRITE_UPDATE_N     = 4'b0011,
    CMD_POWER_DOWN_N       = 4'b0100,
    CMD_NOP                = 4'b1111
  } command_t;

  localparam logic [3:0] ADDR_ALL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/ltc2600_update_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ltc2600_update_sequencer_if                                          |
// | Control-side update/power-down strobes and writer-side transaction.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface ltc2600_update_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CH       = 8
);
  localparam int CH_W = $clog2(N_CH);

  logic                  upd_valid;
  logic [CH_W-1:0]       upd_ch;
  logic [DATA_WIDTH-1:0] upd_data;
  logic                  pd_valid;
  logic [CH_W-1:0]       pd_ch;
  logic                  err_clr;
  logic [3:0]            dac_cmd;
  logic [3:0]            dac_addr;
  logic [DATA_WIDTH-1:0] dac_data;
  logic                  dac_start;
  logic                  dac_done;
  logic                  busy;
  logic [N_CH-1:0]       pending;
  logic                  err;

  modport master (
    output upd_valid, upd_ch, upd_data, pd_valid, pd_ch, err_clr, dac_done,
    input  dac_cmd, dac_addr, dac_data, dac_start, busy, pending, err
  );

  modport slave (
    input  upd_valid, upd_ch, upd_data, pd_valid, pd_ch, err_clr, dac_done,
    output dac_cmd, dac_addr, dac_data, dac_start, busy, pending, err
  );

endinterface
`default_nettype wire

// File: rtl/ltc2600_update_sequencer_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ltc2600_rr_pick                                                      |
// | Round-robin first-set finder, scanning upward from i_ptr+1 with wrap.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ltc2600_rr_pick #(
  parameter  int N_CH = 8,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic [CH_W-1:0] o_idx,
  output logic            o_found
);

  logic [CH_W-1:0] w_cand;

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N_CH; k++) begin
      w_cand = CH_W'((int'(i_ptr) + k) % N_CH);
      if (!o_found && i_req[w_cand]) begin
        o_idx   = w_cand;
        o_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ltc2600_update_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ltc2600_update_sequencer                                             |
// | Per-channel shadow/pending store feeding one DAC transaction at once.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ltc2600_update_sequencer #(
  parameter int DATA_WIDTH     = 16,
  parameter int N_CH           = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rstn,
  ltc2600_update_sequencer_if.slave bus
);
  import ltc2600_pkg::*;

  localparam int CH_W       = $clog2(N_CH);
  localparam int CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_CYCLES = 2;

  seq_state_t            r_state;
  seq_state_t            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shadow [N_CH];
  logic [N_CH-1:0]       r_dirty;
  logic [N_CH-1:0]       r_pd;
  logic [N_CH-1:0]       w_dirty_nxt;
  logic [N_CH-1:0]       w_pd_nxt;
  logic [N_CH-1:0]       w_req;
  logic [CH_W-1:0]       r_rr_ptr;
  logic [CH_W-1:0]       w_pick_idx;
  logic                  w_pick_found;
  logic                  w_serve_pd;
  logic                  w_launch;
  logic                  w_done;
  logic                  w_timeout;
  logic [CNT_W-1:0]      r_cnt;
  command_t              r_cmd;
  logic [3:0]            r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_start;
  logic                  r_err;

  assign w_req      = r_dirty | r_pd;
  assign w_serve_pd = r_pd[w_pick_idx];

  ltc2600_rr_pick #(.N_CH(N_CH)) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.dac_done) begin
          w_done      = 1'b1;
          w_state_nxt = ST_GAP;
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_cnt == CNT_W'(GAP_CYCLES - 1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Later assignments win: launch-clear < power-down < update.
  always_comb begin
    w_dirty_nxt = r_dirty;
    w_pd_nxt    = r_pd;
    if (w_launch) begin
      if (w_serve_pd) w_pd_nxt[w_pick_idx]    = 1'b0;
      else            w_dirty_nxt[w_pick_idx] = 1'b0;
    end
    if (bus.pd_valid) begin
      w_pd_nxt[bus.pd_ch]    = 1'b1;
      w_dirty_nxt[bus.pd_ch] = 1'b0;
    end
    if (bus.upd_valid) begin
      w_dirty_nxt[bus.upd_ch] = 1'b1;
      w_pd_nxt[bus.upd_ch]    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_CH; i++) r_shadow[i] <= '0;
      r_dirty  <= '0;
      r_pd     <= '0;
      r_rr_ptr <= CH_W'(N_CH - 1);
      r_cnt    <= '0;
      r_cmd    <= CMD_WRITE_N;
      r_addr   <= '0;
      r_data   <= '0;
      r_start  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_dirty <= w_dirty_nxt;
      r_pd    <= w_pd_nxt;
      if (bus.upd_valid) r_shadow[bus.upd_ch] <= bus.upd_data;

      if (w_launch) begin
        r_rr_ptr <= w_pick_idx;
        r_cmd    <= w_serve_pd ? CMD_POWER_DOWN_N : CMD_WRITE_UPDATE_N;
        r_addr   <= 4'(w_pick_idx);
        r_data   <= w_serve_pd ? '0 : r_shadow[w_pick_idx];
        r_start  <= 1'b1;
      end
      if (w_done || w_timeout) r_start <= 1'b0;

      if (w_timeout)        r_err <= 1'b1;
      else if (bus.err_clr) r_err <= 1'b0;

      // Shared counter: WAIT timeout, then GAP length; restarts on every state change.
      if (r_state == ST_IDLE || r_state != w_state_nxt) r_cnt <= '0;
      else                                              r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.dac_cmd   = r_cmd;
  assign bus.dac_addr  = r_addr;
  assign bus.dac_data  = r_data;
  assign bus.dac_start = r_start;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.pending   = w_req;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ltc2600_update_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ltc2600_update_sequencer                                          |
// | Directed self-checking bench for the LTC2600 update sequencer.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ltc2600_update_sequencer;

  localparam int DW  = 16;
  localparam int NCH = 8;
  localparam int TO  = 1023;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  ltc2600_update_sequencer_if #(.DATA_WIDTH(DW), .N_CH(NCH)) bus ();

  ltc2600_update_sequencer #(
    .DATA_WIDTH     (DW),
    .N_CH           (NCH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [2:0] ch, input logic [15:0] d);
    bus.upd_valid = 1'b1;
    bus.upd_ch    = ch;
    bus.upd_data  = d;
    tick();
    bus.upd_valid = 1'b0;
  endtask

  task automatic pdn(input logic [2:0] ch);
    bus.pd_valid = 1'b1;
    bus.pd_ch    = ch;
    tick();
    bus.pd_valid = 1'b0;
  endtask

  task automatic done();
    bus.dac_done = 1'b1;
    tick();
    bus.dac_done = 1'b0;
  endtask

  task automatic wait_launch(input string tag);
    int n = 0;
    while (bus.dac_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, " launch"}, 32'(bus.dac_start), 32'd1);
  endtask

  task automatic chk_txn(input string tag, input logic [3:0] cmd, input logic [3:0] addr,
                         input logic [15:0] data);
    check({tag, " cmd"},  32'(bus.dac_cmd),  32'(cmd));
    check({tag, " addr"}, 32'(bus.dac_addr), 32'(addr));
    check({tag, " data"}, 32'(bus.dac_data), 32'(data));
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin
      tick();
      seen |= bus.dac_start;
    end
    check({tag, " no start"}, 32'(seen), 32'd0);
    check({tag, " idle"},     32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.upd_valid = 1'b0;
    bus.upd_ch    = '0;
    bus.upd_data  = '0;
    bus.pd_valid  = 1'b0;
    bus.pd_ch     = '0;
    bus.err_clr   = 1'b0;
    bus.dac_done  = 1'b0;
    repeat (3) tick();
    check("rst start",   32'(bus.dac_start), 32'd0);
    check("rst busy",    32'(bus.busy),      32'd0);
    check("rst pending", 32'(bus.pending),   32'd0);
    check("rst err",     32'(bus.err),       32'd0);
    check("rst cmd",     32'(bus.dac_cmd),   32'd0);
    check("rst data",    32'(bus.dac_data),  32'd0);
    rstn = 1'b1;
    tick();

    // Single update with exact launch latency and busy tail.
    upd(3'd3, 16'hABCD);
    check("single pending", 32'(bus.pending),   32'h08);
    check("single early",   32'(bus.dac_start), 32'd0);
    tick();
    check("single start", 32'(bus.dac_start), 32'd1);
    chk_txn("single", 4'b0011, 4'd3, 16'hABCD);
    check("single clr", 32'(bus.pending), 32'h00);
    repeat (3) tick();
    check("single hold start", 32'(bus.dac_start), 32'd1);
    check("single hold data",  32'(bus.dac_data),  32'hABCD);
    done();
    check("single fall", 32'(bus.dac_start), 32'd0);
    check("single gap1", 32'(bus.busy),      32'd1);
    tick();
    check("single gap2", 32'(bus.busy), 32'd1);
    tick();
    check("single idle", 32'(bus.busy), 32'd0);

    // Round-robin ordering and wrap 7 -> 0.
    upd(3'd0, 16'h0A0A);
    wait_launch("rr0");
    chk_txn("rr0", 4'b0011, 4'd0, 16'h0A0A);
    upd(3'd5, 16'h5555);
    upd(3'd1, 16'h1111);
    check("rr pending", 32'(bus.pending), 32'h22);
    done();
    wait_launch("rr1");
    chk_txn("rr1", 4'b0011, 4'd1, 16'h1111);
    done();
    wait_launch("rr5");
    chk_txn("rr5", 4'b0011, 4'd5, 16'h5555);
    upd(3'd7, 16'h7777);
    upd(3'd0, 16'h0F0F);
    done();
    wait_launch("rr7");
    chk_txn("rr7", 4'b0011, 4'd7, 16'h7777);
    done();
    wait_launch("rrwrap");
    chk_txn("rrwrap", 4'b0011, 4'd0, 16'h0F0F);
    done();
    quiet("rr end", 8);

    // Coalescing before launch, follow-up for an in-flight update.
    upd(3'd6, 16'h6666);
    wait_launch("co6");
    upd(3'd2, 16'h1111);
    upd(3'd2, 16'h2222);
    done();
    wait_launch("co2");
    chk_txn("co2", 4'b0011, 4'd2, 16'h2222);
    upd(3'd2, 16'h3333);
    check("co follow pending", 32'(bus.pending), 32'h04);
    done();
    wait_launch("co2b");
    chk_txn("co2b", 4'b0011, 4'd2, 16'h3333);
    done();
    quiet("co end", 8);

    // Power-down, then power-down and update colliding on one channel.
    pdn(3'd4);
    wait_launch("pd4");
    chk_txn("pd4", 4'b0100, 4'd4, 16'h0000);
    done();
    tick();
    tick();
    bus.pd_valid  = 1'b1;
    bus.pd_ch     = 3'd4;
    bus.upd_valid = 1'b1;
    bus.upd_ch    = 3'd4;
    bus.upd_data  = 16'h4444;
    tick();
    bus.pd_valid  = 1'b0;
    bus.upd_valid = 1'b0;
    check("pdupd pending", 32'(bus.pending), 32'h10);
    wait_launch("pdupd");
    chk_txn("pdupd", 4'b0011, 4'd4, 16'h4444);
    done();
    quiet("pdupd end", 8);

    // Timeout: start high through launch+TO, falls with err at launch+TO+1.
    upd(3'd1, 16'hBEEF);
    wait_launch("to");
    repeat (TO) tick();
    check("to hold start", 32'(bus.dac_start), 32'd1);
    check("to hold data",  32'(bus.dac_data),  32'hBEEF);
    check("to err early",  32'(bus.err),       32'd0);
    tick();
    check("to fall", 32'(bus.dac_start), 32'd0);
    check("to err",  32'(bus.err),       32'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("to err clr", 32'(bus.err), 32'd0);
    upd(3'd2, 16'h1234);
    wait_launch("to next");
    chk_txn("to next", 4'b0011, 4'd2, 16'h1234);
    done();
    check("to next err", 32'(bus.err), 32'd0);
    quiet("to next end", 6);

    // Timeout coinciding with err_clr: set wins.
    upd(3'd6, 16'h6060);
    wait_launch("to2");
    repeat (TO) tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("to2 set wins", 32'(bus.err),       32'd1);
    check("to2 fall",     32'(bus.dac_start), 32'd0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("to2 clr", 32'(bus.err), 32'd0);
    quiet("to2 end", 6);

    // Asynchronous reset during WAIT.
    upd(3'd5, 16'h5A5A);
    wait_launch("rst");
    upd(3'd6, 16'h6B6B);
    check("rst pending set", 32'(bus.pending), 32'h40);
    #3 rstn = 1'b0;
    #1;
    check("arst start",   32'(bus.dac_start), 32'd0);
    check("arst busy",    32'(bus.busy),      32'd0);
    check("arst pending", 32'(bus.pending),   32'd0);
    check("arst cmd",     32'(bus.dac_cmd),   32'd0);
    check("arst addr",    32'(bus.dac_addr),  32'd0);
    check("arst data",    32'(bus.dac_data),  32'd0);
    tick();
    tick();
    rstn = 1'b1;
    done();
    quiet("post rst", 10);
    check("post rst pending", 32'(bus.pending), 32'd0);
    check("post rst err",     32'(bus.err),     32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
